br_redirect_ctrl: RTL and testbench
===================================

// Module: br_redirect_ctrl
// PURPOSE
//  Sequences recovery after execute-stage branch resolution. Takes the resolved outcome (valid, taken, correct, target, fall-through).
//  On a mispredict it flushes younger stages, then holds a fetch redirect until fetch accepts it.
//  Queues predictor/BTB update records for every resolved branch and drains them to the predictor write port.
//  Sits between the execute branch logic and the fetch/predictor front end.
// PARAMETERS
//  ADDR_W     32  instruction-pointer width
//  UPD_DEPTH  4   update FIFO entries (power of 2, >=2)
//  FLUSH_CYC  2   cycles flush is asserted before redirect (>=1)
// PORTS
//  clk         in   1       clock; all state on rising edge
//  rst         in   1       asynchronous, active-low reset
//  br_val      in   1       resolved branch valid (1 cycle per branch)
//  br_taken    in   1       resolved direction
//  br_correct  in   1       prediction (direction+target) was correct
//  br_fip      in   ADDR_W  actual taken target
//  br_fip_p1   in   ADDR_W  fall-through IP
//  br_pc       in   ADDR_W  IP of the branch (predictor index)
//  stall_ex    out  1       execute must hold br_* and not advance
//  flush       out  1       squash all stages younger than execute
//  redir_val   out  1       fetch redirect request
//  redir_addr  out  ADDR_W  redirect IP
//  redir_rdy   in   1       fetch accepts redirect
//  upd_val     out  1       predictor update record valid
//  upd_pc      out  ADDR_W  update: branch IP
//  upd_taken   out  1       update: direction
//  upd_target  out  ADDR_W  update: br_fip
//  upd_rdy     in   1       predictor consumes record
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, FIFO empty, every output 0, redir_addr=0.
//  Accept: br_val & ~stall_ex. br_val while stall_ex=1 is not consumed; producer holds.
//  FSM IDLE:
//    Accepted mispredict (~br_correct): capture redir_addr = br_taken ? br_fip : br_fip_p1.
//    Load flush counter with FLUSH_CYC-1 and go to FLUSH next cycle.
//  FSM FLUSH: flush=1 each cycle; count down; at 0 go to REDIR.
//  FSM REDIR: redir_val=1, redir_addr stable. On redir_rdy=1, go to IDLE next cycle with redir_val=0.
//  Mispredict-to-redir_val latency is FLUSH_CYC+1 cycles.
//  br_val while state!=IDLE: wrong-path branch, dropped (no FIFO push, no stall).
//  stall_ex = (state==IDLE) & fifo_full. Combinational from state and count only, not from br_val.
//  FIFO: every accepted branch, correct or not, pushes {br_pc, br_taken, br_fip}. The push occurs in the acceptance cycle.
//  FIFO pop: on upd_val & upd_rdy. upd_* show the head entry; upd_val = ~empty.
//  Push+pop in the same cycle: count unchanged. Pointers wrap modulo UPD_DEPTH. Count width is clog2(UPD_DEPTH)+1.
//  Full: no push is possible, because stall_ex blocks acceptance. A pop that cycle frees a slot and stall_ex drops the next cycle.
//  Draining continues in every FSM state; flush does not purge FIFO entries, since they are retired-path branches.
//  redir_rdy outside REDIR: ignored. upd_rdy with empty FIFO: ignored.
// CONFIGURATION
//  BR_REDIRECT_PERF_EN defined adds two outputs:
//    perf_br_cnt   out 32
//    perf_misp_cnt out 32
//  perf_br_cnt counts accepted branches; perf_misp_cnt counts accepted mispredicts. Both saturate at 32'hFFFF_FFFF and reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Correct branch: br_val=1, br_correct=1, br_pc=32'h1000, target=32'h2000, upd_rdy=1.
//     -> no flush; upd_val=1 next cycle with pc=1000, taken=1, target=2000; popped.
//  2. Taken mispredict: br_fip=32'h0000_4000, FLUSH_CYC=2.
//     -> flush=1 for cycles +1 and +2; redir_val=1 at +3 with addr=4000; redir_rdy held low for 3 cycles keeps it; rdy=1 -> IDLE.
//  3. Not-taken mispredict: br_fip_p1=32'h0000_0110 -> redir_addr=32'h110.
//     br_val pulses during FLUSH/REDIR -> dropped; FIFO count unchanged.
//  4. upd_rdy=0, 4 correct branches -> stall_ex=1 after the 4th.
//     A 5th br_val is held; upd_rdy=1 for one cycle -> pop; stall_ex=0; 5th accepted; FIFO order preserved (wrap check).
//  5. Push+pop same cycle at count=2 -> count stays 2; head advances.
//  6. rst=0 asserted asynchronously in REDIR with a non-empty FIFO.
//     -> redir_val, flush, upd_val, stall_ex = 0 immediately; after release the first branch behaves as scenario 1.
//     With BR_REDIRECT_PERF_EN, counters read 0.

Source files
------------

// File: rtl/br_redirect_ctrl.sv
// Branch-resolution recovery sequencer: flush, fetch redirect and predictor update queue.
// Optional performance counters are enabled with `define BR_REDIRECT_PERF_EN.
module br_redirect_ctrl #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned UPD_DEPTH = 4,
   parameter int unsigned FLUSH_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              br_val,
   input  logic              br_taken,
   input  logic              br_correct,
   input  logic [ADDR_W-1:0] br_fip,
   input  logic [ADDR_W-1:0] br_fip_p1,
   input  logic [ADDR_W-1:0] br_pc,
   output logic              stall_ex,
   output logic              flush,
   output logic              redir_val,
   output logic [ADDR_W-1:0] redir_addr,
   input  logic              redir_rdy,
   output logic              upd_val,
   output logic [ADDR_W-1:0] upd_pc,
   output logic              upd_taken,
   output logic [ADDR_W-1:0] upd_target,
   input  logic              upd_rdy
`ifdef BR_REDIRECT_PERF_EN
   ,
   output logic [31:0]       perf_br_cnt,
   output logic [31:0]       perf_misp_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(UPD_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned FC_W  = $clog2(FLUSH_CYC + 1);

   typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic              taken;
      logic [ADDR_W-1:0] target;
   } upd_rec_t;

   state_t            state, state_nxt;
   logic [FC_W-1:0]   fcnt, fcnt_nxt;
   logic              capture;

   upd_rec_t          mem [UPD_DEPTH];
   upd_rec_t          head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              fifo_full, fifo_empty;
   logic              accept, push, pop;

   assign fifo_full  = (count == CNT_W'(UPD_DEPTH));
   assign fifo_empty = (count == '0);
   assign stall_ex   = (state == IDLE) & fifo_full;
   // Branches seen outside IDLE are wrong-path and never enter the queue.
   assign accept     = br_val & ~stall_ex & (state == IDLE);
   assign push       = accept;
   assign pop        = upd_val & upd_rdy;

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      flush     = 1'b0;
      redir_val = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (accept && !br_correct) begin
               state_nxt = FLUSH;
               fcnt_nxt  = FC_W'(FLUSH_CYC - 1);
               capture   = 1'b1;
            end
         end
         FLUSH: begin
            flush = 1'b1;
            if (fcnt == '0) state_nxt = REDIR;
            else            fcnt_nxt  = fcnt - 1'b1;
         end
         REDIR: begin
            redir_val = 1'b1;
            if (redir_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         fcnt       <= '0;
         redir_addr <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         if (capture) redir_addr <= br_taken ? br_fip : br_fip_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{pc: br_pc, taken: br_taken, target: br_fip};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset, so the head is masked while empty to keep outputs at 0.
   assign head       = mem[rd_ptr];
   assign upd_val    = ~fifo_empty;
   assign upd_pc     = fifo_empty ? '0 : head.pc;
   assign upd_taken  = fifo_empty ? 1'b0 : head.taken;
   assign upd_target = fifo_empty ? '0 : head.target;

`ifdef BR_REDIRECT_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_br_cnt   <= '0;
         perf_misp_cnt <= '0;
      end else begin
         if (accept && perf_br_cnt != '1) perf_br_cnt <= perf_br_cnt + 1'b1;
         if (accept && !br_correct && perf_misp_cnt != '1)
            perf_misp_cnt <= perf_misp_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Directed self-checking bench for br_redirect_ctrl (default parameters).
module tb_br_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        br_val = 1'b0, br_taken = 1'b0, br_correct = 1'b1;
   logic [31:0] br_fip = '0, br_fip_p1 = '0, br_pc = '0;
   logic        stall_ex, flush, redir_val, redir_rdy = 1'b0;
   logic [31:0] redir_addr;
   logic        upd_val, upd_taken, upd_rdy = 1'b0;
   logic [31:0] upd_pc, upd_target;
`ifdef BR_REDIRECT_PERF_EN
   logic [31:0] perf_br_cnt, perf_misp_cnt;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;

   br_redirect_ctrl #(.ADDR_W(32), .UPD_DEPTH(4), .FLUSH_CYC(2)) dut (
      .clk(clk), .rst(rst),
      .br_val(br_val), .br_taken(br_taken), .br_correct(br_correct),
      .br_fip(br_fip), .br_fip_p1(br_fip_p1), .br_pc(br_pc),
      .stall_ex(stall_ex), .flush(flush),
      .redir_val(redir_val), .redir_addr(redir_addr), .redir_rdy(redir_rdy),
      .upd_val(upd_val), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_rdy(upd_rdy)
`ifdef BR_REDIRECT_PERF_EN
      , .perf_br_cnt(perf_br_cnt), .perf_misp_cnt(perf_misp_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_br(input logic c, input logic t, input logic [31:0] pc,
                         input logic [31:0] fip, input logic [31:0] fp1);
      br_val = 1'b1; br_correct = c; br_taken = t;
      br_pc = pc; br_fip = fip; br_fip_p1 = fp1;
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc,
                             input logic t, input logic [31:0] tgt);
      check_val({tag, "_val"}, upd_val, 1);
      check_val({tag, "_pc"}, upd_pc, pc);
      check_val({tag, "_taken"}, upd_taken, t);
      check_val({tag, "_tgt"}, upd_target, tgt);
   endtask

   task automatic scen_correct(input string tag);
      upd_rdy = 1'b1;
      set_br(1'b1, 1'b1, 32'h1000, 32'h2000, 32'h1004);
      check_val({tag, "_stall0"}, stall_ex, 0);
      tick();
      br_val = 1'b0;
      check_val({tag, "_noflush"}, flush, 0);
      check_val({tag, "_noredir"}, redir_val, 0);
      check_head(tag, 32'h1000, 1'b1, 32'h2000);
      tick();
      check_val({tag, "_popped"}, upd_val, 0);
   endtask

   initial begin
      // reset state
      #2;
      check_val("rst_stall", stall_ex, 0);
      check_val("rst_flush", flush, 0);
      check_val("rst_redir", redir_val, 0);
      check_val("rst_addr", redir_addr, 0);
      check_val("rst_upd", upd_val, 0);
      check_val("rst_upd_pc", upd_pc, 0);
      tick();
      rst = 1'b1;
      tick();

      // 1: correct branch
      scen_correct("s1");

      // 2: taken mispredict, redirect held while redir_rdy low
      set_br(1'b0, 1'b1, 32'h3000, 32'h4000, 32'h3004);
      tick();
      br_val = 1'b0;
      check_val("s2_flush1", flush, 1);
      check_val("s2_redir1", redir_val, 0);
      check_head("s2_push", 32'h3000, 1'b1, 32'h4000);
      tick();
      check_val("s2_flush2", flush, 1);
      check_val("s2_drained", upd_val, 0);
      tick();
      check_val("s2_flush3", flush, 0);
      for (int i = 0; i < 3; i++) begin
         check_val("s2_redir_hold", redir_val, 1);
         check_val("s2_addr", redir_addr, 32'h4000);
         tick();
      end
      check_val("s2_redir_still", redir_val, 1);
      redir_rdy = 1'b1;
      tick();
      redir_rdy = 1'b0;
      check_val("s2_idle", redir_val, 0);

      // 3: not-taken mispredict; wrong-path pulses dropped
      upd_rdy = 1'b0;
      set_br(1'b0, 1'b0, 32'h0100, 32'h5000, 32'h0110);
      tick();
      set_br(1'b1, 1'b1, 32'h0BAD, 32'h0BAD, 32'h0BAD);
      check_val("s3_flush", flush, 1);
      check_val("s3_nostall", stall_ex, 0);
      tick();
      set_br(1'b0, 1'b1, 32'h0BA2, 32'h0BA2, 32'h0BA2);
      tick();
      set_br(1'b1, 1'b0, 32'h0BA3, 32'h0BA3, 32'h0BA3);
      check_val("s3_redir", redir_val, 1);
      check_val("s3_addr", redir_addr, 32'h0110);
      tick();
      redir_rdy = 1'b1;
      tick();
      redir_rdy = 1'b0;
      br_val = 1'b0;
      check_val("s3_idle", redir_val, 0);
      upd_rdy = 1'b1;
      check_head("s3_rec", 32'h0100, 1'b0, 32'h5000);
      tick();
      check_val("s3_one_entry", upd_val, 0);

      // 4: fill, stall, single pop, wrap
      upd_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_br(1'b1, i[0], 32'hA0 + i, 32'hB0 + i, 32'h0);
         tick();
      end
      set_br(1'b1, 1'b0, 32'hA4, 32'hB4, 32'h0);
      check_val("s4_full", stall_ex, 1);
      tick();
      check_val("s4_held", stall_ex, 1);
      check_val("s4_head", upd_pc, 32'hA0);
      upd_rdy = 1'b1;
      tick();
      upd_rdy = 1'b0;
      check_val("s4_unstall", stall_ex, 0);
      check_val("s4_head1", upd_pc, 32'hA1);
      tick();
      br_val = 1'b0;
      check_val("s4_full2", stall_ex, 1);
      upd_rdy = 1'b1;
      for (int i = 1; i < 5; i++) begin
         check_head("s4_order", 32'hA0 + i, (i == 4) ? 1'b0 : i[0], 32'hB0 + i);
         tick();
      end
      check_val("s4_empty", upd_val, 0);
      check_val("s4_nostall", stall_ex, 0);

      // 5: push+pop at count 2
      upd_rdy = 1'b0;
      set_br(1'b1, 1'b1, 32'hC0, 32'hD0, 32'h0);
      tick();
      set_br(1'b1, 1'b1, 32'hC1, 32'hD1, 32'h0);
      tick();
      set_br(1'b1, 1'b0, 32'hC2, 32'hD2, 32'h0);
      upd_rdy = 1'b1;
      tick();
      br_val = 1'b0;
      check_head("s5_adv", 32'hC1, 1'b1, 32'hD1);
      tick();
      check_head("s5_next", 32'hC2, 1'b0, 32'hD2);
      tick();
      check_val("s5_cnt2", upd_val, 0);

      // 6: async reset while redirecting with queued records
      upd_rdy = 1'b0;
      set_br(1'b1, 1'b1, 32'hE0, 32'hE8, 32'h0);
      tick();
      set_br(1'b0, 1'b1, 32'hE4, 32'h6000, 32'hE8);
      tick();
      br_val = 1'b0;
      tick();
      tick();
      check_val("s6_redir", redir_val, 1);
      check_val("s6_upd", upd_val, 1);
`ifdef BR_REDIRECT_PERF_EN
      check_val("s6_perf_br", perf_br_cnt, 13);
      check_val("s6_perf_misp", perf_misp_cnt, 3);
`endif
      #2;
      rst = 1'b0;
      #1;
      check_val("s6_rst_redir", redir_val, 0);
      check_val("s6_rst_flush", flush, 0);
      check_val("s6_rst_upd", upd_val, 0);
      check_val("s6_rst_stall", stall_ex, 0);
      check_val("s6_rst_addr", redir_addr, 0);
`ifdef BR_REDIRECT_PERF_EN
      check_val("s6_rst_pbr", perf_br_cnt, 0);
      check_val("s6_rst_pmisp", perf_misp_cnt, 0);
`endif
      tick();
      rst = 1'b1;
      tick();
      scen_correct("s6_post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1);
   end

endmodule
